pulse_gen: RTL and testbench
============================

PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 clk_i  input  1  single system clock; all state SHALL update on its rising edge.
REQ-002 rst_i  input  1  reset; SHALL be asynchronous and active-high.
REQ-003 start_i  input  1  request to begin a burst; sampled on clk_i.
REQ-004 stop_i  input  1  abort an in-progress burst; sampled on clk_i.
REQ-005 count_i  input  9  number of pulses N in the burst, unsigned.
REQ-006 period_i  input  28  pulse spacing P in clk_i cycles, unsigned.
REQ-007 pulse_o  output  1  registered one-cycle strobe, the generated pulse train.
REQ-008 busy_o  output  1  high while a burst is running.
REQ-009 done_o  output  1  one-cycle strobe marking normal burst completion.
REQ-010 sent_o  output  9  number of pulses emitted in the current or last burst.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE.
REQ-012 IDLE: start_i=1 at edge k SHALL latch count_i and period_i, clear sent_o, and enter RUN, or enter DONE if count_i=0.
REQ-013 Latched P=0 SHALL be treated as P=1, giving one pulse every cycle.
REQ-014 RUN: pulse_o SHALL be 1 in cycles k+1, k+1+P, ..., k+1+(N-1)P and 0 otherwise.
REQ-015 sent_o SHALL increment in the same cycle that pulse_o is 1, reaching N on the last pulse.
REQ-016 The internal period counter SHALL count 0..P-1 and wrap, with a pulse issued at 0; the count SHALL never exceed P-1.
REQ-017 After the Nth pulse cycle, the FSM SHALL enter DONE; done_o=1 and busy_o=0 in cycle k+2+(N-1)P.
REQ-018 count_i=0: there SHALL be no pulse; done_o=1 in cycle k+1; sent_o=0.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-020 busy_o SHALL be 1 exactly while the state is RUN.
REQ-021 start_i in RUN or DONE SHALL be ignored; changes on count_i and period_i SHALL not affect a running burst.
REQ-022 stop_i=1 in RUN at edge j SHALL force IDLE from cycle j+1 with pulse_o=0, busy_o=0 and done_o=0; sent_o SHALL hold its value.
REQ-023 stop_i and start_i both 1 in IDLE: stop_i SHALL win and no burst SHALL start.
REQ-024 stop_i in IDLE or DONE SHALL have no effect.
REQ-025 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 rst_i=1 SHALL immediately force IDLE, pulse_o=0, busy_o=0, done_o=0, sent_o=0, and clear the period counter and latched N and P.
REQ-027 Reset mid-burst SHALL abort the burst without a done_o pulse; the first start_i after deassertion SHALL behave as from power-up.

Structure
REQ-028 Shared package pulse_gen_pkg SHALL hold the state enum (IDLE, RUN, DONE), CNT_W=9 and PER_W=28.
REQ-029 A single sub-module period_timer SHALL implement the 28-bit wrap counter (inputs: load/clear, period; output: tick at 0); the FSM, N tracking and outputs SHALL stay in pulse_gen.

Verification
REQ-030 N=3, P=4, start at edge 10 -> pulse_o high in cycles 11, 15 and 19; done_o in cycle 20; sent_o=3; busy_o in cycles 11-19.
REQ-031 N=5, P=0 -> pulse_o high in cycles k+1..k+5 consecutively; done_o in cycle k+6.
REQ-032 N=0 -> no pulse; done_o in cycle k+1; busy_o never high.
REQ-033 N=4, P=10, stop_i after the 2nd pulse -> no further pulse, no done_o, sent_o=2, busy_o=0 the next cycle.
REQ-034 N=511, P=2 with start_i re-asserted and count_i/period_i changed mid-burst -> exactly 511 pulses at spacing 2; sent_o=511 with no wrap.
REQ-035 rst_i asserted asynchronously mid-burst (between edges) -> all outputs 0 before the next edge; a fresh start with N=1, P=1 then yields one pulse at k+1 and done_o at k+2.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse_gen burst generator.
package pulse_gen_pkg;

  localparam int CNT_W = 9;
  localparam int PER_W = 28;

  localparam logic [CNT_W-1:0] CNT_ONE = 9'd1;
  localparam logic [PER_W-1:0] PER_ONE = 28'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A programmed spacing of zero behaves as one pulse per cycle.
  function automatic logic [PER_W-1:0] eff_period(input logic [PER_W-1:0] p);
    return (p == 28'd0) ? PER_ONE : p;
  endfunction

endpackage

// File: rtl/pulse_gen_period_timer.sv
// Wrap counter 0..P-1 that flags the cycles on which a pulse is due.
module period_timer
  import pulse_gen_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [PER_W-1:0] period_i,
  output logic             tick_o
);

  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] cnt_q, cnt_d;

  // Next-state: clear, load (first pulse is issued on the load edge, so the
  // count resumes at 1), or advance with wrap at P-1.
  always_comb begin
    per_d = per_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      per_d = 28'd0;
      cnt_d = 28'd0;
    end else if (load_i) begin
      per_d = eff_period(period_i);
      cnt_d = (eff_period(period_i) == PER_ONE) ? 28'd0 : PER_ONE;
    end else if (en_i) begin
      cnt_d = (cnt_q == (per_q - PER_ONE)) ? 28'd0 : (cnt_q + PER_ONE);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Latched period and running count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      per_q <= 28'd0;
      cnt_q <= 28'd0;
    end else begin
      per_q <= per_d;
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == 28'd0);

endmodule

// File: rtl/pulse_gen.sv
// Burst pulse generator: N registered strobes spaced P cycles apart.
module pulse_gen
  import pulse_gen_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [PER_W-1:0] period_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sent_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic load_s;
  logic clear_s;
  logic en_s;
  logic tick_s;

  // Timer is loaded when a non-empty burst starts and frozen at zero otherwise.
  always_comb begin
    load_s  = (state_q == IDLE) && start_i && !stop_i && (count_i != 9'd0);
    en_s    = (state_q == RUN);
    clear_s = (state_q != RUN) && !load_s;
  end

  period_timer u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load_s),
    .clear_i  (clear_s),
    .en_i     (en_s),
    .period_i (period_i),
    .tick_o   (tick_s)
  );

  // FSM and output next-state; strobes default low every cycle.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    sent_d  = sent_q;
    pulse_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          n_d = count_i;
          if (count_i == 9'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            sent_d  = 9'd0;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            pulse_d = 1'b1;
            sent_d  = CNT_ONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (sent_q == n_q) begin
          // All pulses issued: completion is reported one cycle after the last.
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          if (tick_s) begin
            pulse_d = 1'b1;
            sent_d  = sent_q + CNT_ONE;
          end else begin
            pulse_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      n_q     <= 9'd0;
      sent_q  <= 9'd0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      sent_q  <= sent_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sent_o  = sent_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Randomised bench for pulse_gen against a timing-formula reference model.
module tb_pulse_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [8:0]  count = 9'd0;
  logic [27:0] period = 28'd0;
  logic        pulse, busy, done;
  logic [8:0]  sent;

  pulse_gen dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .stop_i   (stop),
    .count_i  (count),
    .period_i (period),
    .pulse_o  (pulse),
    .busy_o   (busy),
    .done_o   (done),
    .sent_o   (sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a burst started at edge k with N pulses, spacing P,
  // pulses on edges k + i*P (i < N), completes on edge k + (N-1)P + 1.
  int     ecnt = 0;
  bit     m_run = 1'b0;
  bit     m_cool = 1'b0;
  longint m_k, m_n, m_p, m_last, m_d;
  logic   e_pulse = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  int     e_sent = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_cool = 1'b0;
      e_pulse = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_sent = 0;
    end else begin
      ecnt = ecnt + 1;
      e_pulse = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (m_run) begin
        m_last = m_k + (m_n - 1) * m_p + 1;
        if (stop) begin
          m_run = 1'b0;
        end else if (ecnt == m_last) begin
          e_done = 1'b1; e_sent = int'(m_n); m_run = 1'b0; m_cool = 1'b1;
        end else begin
          m_d = ecnt - m_k;
          e_busy = 1'b1;
          e_pulse = ((m_d % m_p) == 0);
          e_sent = int'(m_d / m_p) + 1;
        end
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else if (start && !stop) begin
        if (count == 9'd0) begin
          e_done = 1'b1; e_sent = 0; m_cool = 1'b1;
        end else begin
          m_run = 1'b1; m_k = ecnt; m_n = count;
          m_p = (period == 28'd0) ? 1 : period;
          e_pulse = 1'b1; e_busy = 1'b1; e_sent = 1;
        end
      end
    end
  end

  int pulse_tally = 0;

  task automatic step();
    @(negedge clk);
    check_eq("pulse", pulse, e_pulse);
    check_eq("busy",  busy,  e_busy);
    check_eq("done",  done,  e_done);
    check_eq("sent",  sent,  e_sent);
    if (pulse) pulse_tally++;
  endtask

  task automatic idle(input int n);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic launch(input int n, input int p);
    count = n[8:0]; period = p[27:0]; start = 1'b1; stop = 1'b0;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_eq("reset_sent", sent, 32'd0);
    check_eq("reset_busy", busy, 32'd0);
    rst = 1'b0;
    idle(3);

    // N=3, P=4
    launch(3, 4);
    idle(15);
    // N=5, P=0
    launch(5, 0);
    idle(10);
    // N=0
    launch(0, 7);
    idle(4);
    // start and stop together in IDLE
    count = 9'd3; period = 28'd2; start = 1'b1; stop = 1'b1;
    step();
    check_eq("start_stop_busy", busy, 32'd0);
    idle(3);

    // N=4, P=10, stop after second pulse (pulses on edges k and k+10)
    launch(4, 10);
    idle(11);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("stop_sent", sent, 32'd2);
    check_eq("stop_busy", busy, 32'd0);
    idle(40);

    // N=511, P=2 with noise on start/count/period during the burst
    pulse_tally = 0;
    launch(511, 2);
    for (int i = 1; i <= 1020; i++) begin
      start  = $urandom_range(0, 1) == 1;
      count  = 9'($urandom);
      period = 28'($urandom);
      step();
    end
    start = 1'b0;
    idle(5);
    check_eq("long_pulses", pulse_tally, 32'd511);
    check_eq("long_sent",   sent,        32'd511);

    // Asynchronous reset mid-burst, then a fresh N=1, P=1 burst
    launch(6, 3);
    idle(4);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_pulse", pulse, 32'd0);
    check_eq("arst_busy",  busy,  32'd0);
    check_eq("arst_done",  done,  32'd0);
    check_eq("arst_sent",  sent,  32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    launch(1, 1);
    check_eq("fresh_pulse", pulse, 32'd1);
    step();
    check_eq("fresh_done", done, 32'd1);
    idle(3);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      stop   = ($urandom_range(0, 15) == 0);
      count  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 5));
      period = ($urandom_range(0, 9) == 0) ? 28'($urandom_range(0, 40)) : 28'($urandom_range(0, 5));
      step();
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
